// File: rtl/sys_top_wrapper.sv
// sys_top_wrapper: UART-controlled byte RAM and GPIO register.
// Host commands arrive over an 8N1 UART:
//   'S' addr[4] len[3] data...  write bytes into RAM, reply 'K'
//   'R' addr[4] len[3]          stream bytes out of RAM, then 'K'
//   'G' lo hi                   load gpio with {hi[0], lo}, reply 'K'
//   anything else               reply '?'
// All multi-byte fields are little-endian. Addresses wrap modulo MEM_BYTES.
module sys_top_wrapper #(
  parameter int CLK_HZ    = 200_000_000,
  parameter int BIT_RATE  = 115200,
  parameter int MEM_BYTES = 1024
) (
  input  logic       diff_clk_200mhz_clk_p,
  input  logic       diff_clk_200mhz_clk_n,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [8:0] gpio
);

  localparam int DIV = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(MEM_BYTES);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LEN   = 3'd2,
    WDATA = 3'd3,
    GDATA = 3'd4,
    RSEND = 3'd5,
    ACK   = 3'd6
  } cmd_state_e;

  logic clk;
  logic unused_clk_n;
  assign clk          = diff_clk_200mhz_clk_p;
  assign unused_clk_n = diff_clk_200mhz_clk_n;

  // receive synchroniser and previous-sample flop for start-edge detection
  logic sync1_q, sync2_q, rx_prev_q;

  // receiver state
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_byte_q, rx_byte_d;

  // transmitter state
  logic          tx_busy_q, tx_busy_d;
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          txd_q, txd_d;

  // command engine state
  cmd_state_e    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [23:0]   len_q, len_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic          is_read_q, is_read_d;
  logic [7:0]    reply_q, reply_d;
  logic [8:0]    gpio_q, gpio_d;
  logic [7:0]    g_lo_q, g_lo_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          rd_pend_q, rd_pend_d;
  logic          mem_we_s;
  logic          tx_free_s;

  // byte RAM with registered read port; contents survive reset
  logic [7:0]    mem_q [MEM_BYTES];
  logic [7:0]    rd_data_q;

  assign uart_txd  = txd_q;
  assign gpio      = gpio_q;
  // a pending start pulse counts as busy so two bytes are never launched back to back
  assign tx_free_s = !tx_busy_q && !tx_start_q;

  // two-flop synchroniser on the asynchronous receive line, idle-high on reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= uart_rxd;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // receiver: falling edge, mid-start recheck, 8 data bits LSB first, stop check
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !sync2_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (sync2_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_shift_q;
          end else begin
            rx_valid_d = 1'b0;
          end
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // transmitter: 10-bit frame shifted out LSB first, one bit every DIV clocks
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    txd_d      = txd_q;
    if (!tx_busy_q) begin
      if (tx_start_q) begin
        tx_busy_d  = 1'b1;
        tx_shift_d = {1'b1, tx_data_q, 1'b0};
        tx_bit_d   = 4'd0;
        tx_cnt_d   = '0;
        txd_d      = 1'b0;
      end else begin
        txd_d = 1'b1;
      end
    end else if (tx_cnt_q == DIV_M1) begin
      tx_cnt_d = '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        txd_d     = 1'b1;
      end else begin
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        txd_d      = tx_shift_q[1];
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end else begin
      tx_cnt_d = tx_cnt_q + CW'(1);
    end
  end

  // command engine: parses host bytes, drives RAM writes, read-out and replies
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    is_read_d  = is_read_q;
    reply_d    = reply_q;
    gpio_d     = gpio_q;
    g_lo_d     = g_lo_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    rd_pend_d  = rd_pend_q;
    mem_we_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid_q) begin
          bcnt_d = 2'd0;
          case (rx_byte_q)
            8'h53:   begin state_d = ADDR;  is_read_d = 1'b0; end
            8'h52:   begin state_d = ADDR;  is_read_d = 1'b1; end
            8'h47:   begin state_d = GDATA; end
            default: begin state_d = ACK;   reply_d = 8'h3F; end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (rx_valid_q) begin
          addr_d = {rx_byte_q, addr_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            bcnt_d  = 2'd0;
            state_d = LEN;
          end else begin
            state_d = ADDR;
          end
        end else begin
          state_d = ADDR;
        end
      end
      LEN: begin
        if (rx_valid_q) begin
          len_d  = {rx_byte_q, len_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd2) begin
            bcnt_d = 2'd0;
            if ({rx_byte_q, len_q[23:8]} == 24'd0) begin
              state_d = ACK;
              reply_d = 8'h4B;
            end else begin
              state_d = is_read_q ? RSEND : WDATA;
            end
          end else begin
            state_d = LEN;
          end
        end else begin
          state_d = LEN;
        end
      end
      WDATA: begin
        if (rx_valid_q) begin
          mem_we_s = 1'b1;
          addr_d   = addr_q + 32'd1;
          len_d    = len_q - 24'd1;
          if (len_q == 24'd1) begin
            state_d = ACK;
            reply_d = 8'h4B;
          end else begin
            state_d = WDATA;
          end
        end else begin
          state_d = WDATA;
        end
      end
      GDATA: begin
        if (rx_valid_q) begin
          if (bcnt_q == 2'd0) begin
            g_lo_d = rx_byte_q;
            bcnt_d = 2'd1;
          end else begin
            gpio_d  = {rx_byte_q[0], g_lo_q};
            bcnt_d  = 2'd0;
            state_d = ACK;
            reply_d = 8'h4B;
          end
        end else begin
          state_d = GDATA;
        end
      end
      RSEND: begin
        // rd_pend marks the cycle in which rd_data_q holds RAM[addr]
        if (rd_pend_q) begin
          rd_pend_d  = 1'b0;
          tx_start_d = 1'b1;
          tx_data_d  = rd_data_q;
          addr_d     = addr_q + 32'd1;
          len_d      = len_q - 24'd1;
          if (len_q == 24'd1) begin
            state_d = ACK;
            reply_d = 8'h4B;
          end else begin
            state_d = RSEND;
          end
        end else if (tx_free_s) begin
          rd_pend_d = 1'b1;
        end else begin
          rd_pend_d = 1'b0;
        end
      end
      ACK: begin
        if (tx_free_s) begin
          tx_start_d = 1'b1;
          tx_data_d  = reply_q;
          state_d    = IDLE;
        end else begin
          state_d = ACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers for receiver, transmitter and command engine
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'd0;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= 10'h3FF;
      tx_bit_q   <= 4'd0;
      tx_cnt_q   <= '0;
      txd_q      <= 1'b1;
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      len_q      <= 24'd0;
      bcnt_q     <= 2'd0;
      is_read_q  <= 1'b0;
      reply_q    <= 8'd0;
      gpio_q     <= 9'h000;
      g_lo_q     <= 8'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'd0;
      rd_pend_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
      txd_q      <= txd_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      is_read_q  <= is_read_d;
      reply_q    <= reply_d;
      gpio_q     <= gpio_d;
      g_lo_q     <= g_lo_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  // RAM write port and one-clock-latency read port, indexed by the low address bits
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[addr_q[AW-1:0]] <= rx_byte_q;
    end
    rd_data_q <= mem_q[addr_q[AW-1:0]];
  end

endmodule

// File: tb/tb_sys_top_wrapper.sv
// Directed testbench for sys_top_wrapper, run with a short bit period (DIV=6)
// so full 256-byte transfers fit in a modest cycle count.
`timescale 1ns/1ps
module tb_sys_top_wrapper;

  localparam int DIV = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       txd;
  logic [8:0] gpio;

  int tests = 0;
  int fails = 0;

  logic [8:0] rx_q [$];   // decoded frames from uart_txd: {stop, data}
  int         hi_q [$];   // cycles from start edge until the line first went high

  sys_top_wrapper #(.CLK_HZ(DIV), .BIT_RATE(1), .MEM_BYTES(1024)) dut (
    .diff_clk_200mhz_clk_p(clk),
    .diff_clk_200mhz_clk_n(~clk),
    .reset(reset),
    .uart_rxd(rxd),
    .uart_txd(txd),
    .gpio(gpio)
  );

  always #5 clk = ~clk;

  // watchdog so the run always ends
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // UART monitor on uart_txd, sampling on falling clock edges
  initial begin
    logic       prev;
    logic [8:0] frame;
    int         hi;
    bit         seen;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !txd) begin
        seen = 0;
        hi = 0;
        frame = 9'd0;
        for (int c = 1; c <= DIV/2 + 9*DIV; c++) begin
          @(negedge clk);
          if (!seen && txd) begin
            hi = c;
            seen = 1;
          end
          if (c > DIV/2 && ((c - DIV/2) % DIV) == 0) begin
            frame[(c - DIV/2) / DIV - 1] = txd;
          end
        end
        rx_q.push_back(frame);
        hi_q.push_back(hi);
      end
      prev = txd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [23:0] l);
    send_byte(c);
    send_byte(a[7:0]);   send_byte(a[15:8]);
    send_byte(a[23:16]); send_byte(a[31:24]);
    send_byte(l[7:0]);   send_byte(l[15:8]);  send_byte(l[23:16]);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b, output int hi);
    int n;
    logic [8:0] f;
    n = 0;
    hi = 0;
    while (rx_q.size() == 0 && n < 30*DIV) begin
      @(negedge clk);
      n++;
    end
    if (rx_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: no frame within budget, expected %0h", tag, b);
    end else begin
      f  = rx_q.pop_front();
      hi = hi_q.pop_front();
      check(tag, {23'd0, f}, {23'd0, 1'b1, b});
    end
  endtask

  task automatic expect_none(input string tag);
    repeat (12*DIV) @(negedge clk);
    check(tag, rx_q.size(), 32'd0);
  endtask

  // directed sequence
  initial begin
    int hi;
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_gpio", {23'd0, gpio}, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // fill RAM[0..255] with 0x00..0xFF; no reply until the last data byte
    send_cmd(8'h53, 32'h0000_0000, 24'h000100);
    for (int i = 0; i < 255; i++) send_byte(8'(i));
    check("wr256_early_reply", rx_q.size(), 32'd0);
    send_byte(8'hFF);
    expect_byte("wr256_ack", 8'h4B, hi);
    expect_none("wr256_single_ack");

    // stream RAM[0..255] back, checking bit timing on two frames
    send_cmd(8'h52, 32'h0000_0000, 24'h000100);
    for (int i = 0; i < 256; i++) begin
      expect_byte("rd256_data", 8'(i), hi);
      if (i == 0) check("rd_width_0x00", hi, 9*DIV);
      if (i == 1) check("rd_width_0x01", hi, DIV);
    end
    expect_byte("rd256_ack", 8'h4B, hi);

    // gpio load, then an unknown command leaves gpio alone
    send_byte(8'h47); send_byte(8'hFF); send_byte(8'h01);
    expect_byte("gpio_ack", 8'h4B, hi);
    check("gpio_1ff", {23'd0, gpio}, 32'h1FF);
    send_byte(8'h00);
    expect_byte("unknown_reply", 8'h3F, hi);
    check("gpio_kept", {23'd0, gpio}, 32'h1FF);

    // write across the top of RAM, then read it back
    send_cmd(8'h53, 32'h0000_03FF, 24'h000002);
    send_byte(8'hAA); send_byte(8'hBB);
    expect_byte("wrap_wr_ack", 8'h4B, hi);
    send_cmd(8'h52, 32'h0000_03FF, 24'h000002);
    expect_byte("wrap_rd_3ff", 8'hAA, hi);
    expect_byte("wrap_rd_000", 8'hBB, hi);
    expect_byte("wrap_rd_ack", 8'h4B, hi);

    // start-bit glitch shorter than half a bit
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    expect_none("glitch_no_byte");
    check("glitch_state", 32'(dut.state_q), 32'd0);
    // frame with a zero stop bit is discarded
    send_frame(8'h41, 1'b0);
    expect_none("badstop_no_byte");
    check("badstop_state", 32'(dut.state_q), 32'd0);
    send_byte(8'h41);
    expect_byte("after_badstop", 8'h3F, hi);

    // one byte short of a 256-byte write: no reply, engine waits for the last byte
    send_cmd(8'h53, 32'h0000_0000, 24'h000100);
    for (int i = 0; i < 255; i++) send_byte(8'(i) ^ 8'h5A);
    expect_none("short_wr_no_reply");
    check("short_wr_state", 32'(dut.state_q), 32'd3);
    check("short_wr_len", {8'd0, dut.len_q}, 32'd1);

    // reset in the middle of an incoming frame during WDATA
    rxd = 1'b0;
    repeat (2*DIV) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_txd", {31'd0, txd}, 32'd1);
    check("midrst_gpio", {23'd0, gpio}, 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'd0);
    check("midrst_len", {8'd0, dut.len_q}, 32'd0);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    expect_none("midrst_no_reply");

    // first byte after release is a command; RAM survived the reset
    send_byte(8'h47); send_byte(8'h34); send_byte(8'h01);
    expect_byte("postrst_gpio_ack", 8'h4B, hi);
    check("postrst_gpio", {23'd0, gpio}, 32'h134);
    send_cmd(8'h52, 32'h0000_0000, 24'h000001);
    expect_byte("ram_kept", 8'h5A, hi);
    expect_byte("ram_kept_ack", 8'h4B, hi);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sys_top_wrapper.md
SYS_TOP_WRAPPER -- requirements
Module: sys_top_wrapper

Interface
REQ-001 Parameter CLK_HZ, default 200_000_000; clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 115200; UART baud; divisor DIV = CLK_HZ/BIT_RATE, truncated, giving 1736 clocks per bit.
REQ-003 Parameter MEM_BYTES, default 1024; internal byte RAM depth, a power of two.
REQ-004 diff_clk_200mhz_clk_p  in  1  sole clock; all logic on its rising edge.
REQ-005 diff_clk_200mhz_clk_n  in  1  complement of clk_p; present for board compatibility, unused internally.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 uart_rxd  in  1  UART receive, 8N1, idle high, asynchronous to clock.
REQ-008 uart_txd  out  1  UART transmit, 8N1, idle high.
REQ-009 gpio  out  9  GPIO output register.

Function
REQ-010 uart_rxd SHALL pass through a 2-flop synchroniser whose flops reset to 1.
REQ-011 RX: a falling edge in idle starts a frame; at DIV/2 the line is re-sampled; if high, RX aborts to idle (glitch).
REQ-012 RX: 8 data bits SHALL be sampled LSB first at DIV-clock intervals after the start mid-point, then the stop bit.
REQ-013 RX: a valid stop bit (1) SHALL produce a one-cycle rx_valid strobe with the byte; a stop bit of 0 SHALL discard the byte, with no strobe.
REQ-014 TX: when idle and given a byte, TX SHALL send a start bit, 8 data bits LSB first and one stop bit, each DIV clocks, then return to idle.
REQ-015 TX SHALL raise busy for the whole frame; a new byte is accepted only when not busy.
REQ-016 Command FSM states: IDLE, ADDR, LEN, WDATA, GDATA, RSEND, ACK.
REQ-017 IDLE: received 0x53 ('S') -> ADDR (write); 0x52 ('R') -> ADDR (read); 0x47 ('G') -> GDATA; any other byte -> ACK with reply 0x3F ('?').
REQ-018 ADDR SHALL collect 4 bytes, little-endian, into the 32-bit address, then go to LEN.
REQ-019 LEN SHALL collect 3 bytes, little-endian, into a 24-bit length; then length 0 -> ACK with 0x4B ('K'); write -> WDATA; read -> RSEND.
REQ-020 WDATA: each received byte SHALL be written to RAM[addr mod MEM_BYTES]; then addr increments and length decrements.
REQ-021 WDATA: when length reaches 0 the FSM SHALL go to ACK with reply 0x4B.
REQ-022 RSEND: each time TX is not busy, the FSM SHALL transmit RAM[addr mod MEM_BYTES], increment addr and decrement length; at length 0 -> ACK with 0x4B.
REQ-023 Addresses SHALL wrap modulo MEM_BYTES; the upper address bits are ignored.
REQ-024 GDATA SHALL collect 2 bytes, little-endian; gpio <= value[8:0] on the second byte, then ACK with 0x4B.
REQ-025 ACK: when TX is not busy, the FSM SHALL send the reply byte and return to IDLE.
REQ-026 Bytes received in RSEND or ACK SHALL be dropped.
REQ-027 RAM reads SHALL be synchronous, one clock of latency; the FSM accounts for this before handing the byte to TX.

Reset
REQ-028 While reset=0 at a clock edge: FSM -> IDLE; RX and TX -> idle; uart_txd=1; gpio=9'h000; address, length and counters -> 0.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-frame or mid-command SHALL abort the operation: no reply byte, no partial TX frame completion, and the first byte after release is treated as a command.

Verification
REQ-031 Send 53 00 00 00 00 00 01 00, then bytes 0x00..0xFF at 115200 -> RAM[0..255] = 0x00..0xFF; one 0x4B is sent only after the 256th data byte.
REQ-032 Send 53 + addr 0 + len 256 + only 255 data bytes -> no reply; the FSM stays in WDATA with length 1.
REQ-033 Send 52 00 00 00 00 00 01 00 after REQ-031 -> 256 bytes 0x00..0xFF on uart_txd, then 0x4B, each frame 1736 clocks per bit.
REQ-034 Send 47 FF 01 -> gpio=9'h1FF, reply 0x4B; then send 0x00 -> reply 0x3F and gpio unchanged.
REQ-035 Send 53 FF 03 00 00 02 00 00 AA BB -> RAM[0x3FF]=AA, RAM[0x000]=BB, reply 0x4B.
REQ-036 A start-bit glitch shorter than DIV/2, and a frame with stop bit 0 -> no byte accepted; assert reset=0 during WDATA -> uart_txd=1, gpio=0, FSM in IDLE.
